// File: rtl/edge_detect_filtered_multi.sv
// Multi-channel debounced edge detector: per-channel synchronizer, persistence
// filter, qualified rise/fall detection, stretched pulse and sticky event flag.
module edge_detect_filtered_multi #(
  parameter int WIDTH         = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int PULSE_LEN     = 1
) (
  input  logic             clk,
  input  logic             ares_n,
  input  logic             sres,
  input  logic             ld_en,
  input  logic [WIDTH-1:0] level_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] flag_clr,
  output logic [WIDTH-1:0] level_filt,
  output logic [WIDTH-1:0] pulse_out,
  output logic [WIDTH-1:0] event_flag,
  output logic             any_event
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam int SW = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [SW-1:0] STRETCH  = SW'(PULSE_LEN);

  logic [WIDTH-1:0] sync_q;

  // The synchronizer runs freely: neither ld_en nor sres touches it.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_q = level_in;
  end else begin : g_sync
    logic [WIDTH-1:0] sync_ff [SYNC_STAGES];

    always_ff @(posedge clk or negedge ares_n) begin
      if (!ares_n) begin
        // NOTE: every flop in this small array is reset; it holds metastability-
        // hardened state, not bulk storage, so clearing it is cheap and required.
        for (int s = 0; s < SYNC_STAGES; s++) sync_ff[s] <= '0;
      end else begin
        sync_ff[0] <= level_in;
        for (int s = 1; s < SYNC_STAGES; s++) sync_ff[s] <= sync_ff[s-1];
      end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          filt_q, filt_d;
    logic          pulse_q, pulse_d;
    logic          flag_q, flag_d;
    logic          commit, qual;

    always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      cnt_d  = cnt_q;
      filt_d = filt_q;
      scnt_d = scnt_q;
      flag_d = flag_q;
      commit = 1'b0;
      qual   = 1'b0;

      if (ld_en) begin
        if (sync_q[i] == filt_q) begin
          cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
          cnt_d  = '0;
          filt_d = sync_q[i];
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        qual = commit & (sync_q[i] ? rise_en[i] : fall_en[i]);

        // A qualified edge reloads the stretch, so back-to-back edges merge.
        if (qual)                scnt_d = STRETCH;
        else if (scnt_q != '0)   scnt_d = scnt_q - 1'b1;
      end

      // Set beats clear when both land on the same cycle.
      if (qual)             flag_d = 1'b1;
      else if (flag_clr[i]) flag_d = 1'b0;

      if (sres) begin
        cnt_d  = '0;
        filt_d = 1'b0;
        scnt_d = '0;
        flag_d = 1'b0;
      end

      pulse_d = (scnt_d != '0);
    end

    always_ff @(posedge clk or negedge ares_n) begin
      if (!ares_n) begin
        cnt_q   <= '0;
        filt_q  <= 1'b0;
        scnt_q  <= '0;
        pulse_q <= 1'b0;
        flag_q  <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        cnt_q   <= cnt_d;
        filt_q  <= filt_d;
        scnt_q  <= scnt_d;
        pulse_q <= pulse_d;
        flag_q  <= flag_d;
      end
    end

    assign level_filt[i] = filt_q;
    assign pulse_out[i]  = pulse_q;
    assign event_flag[i] = flag_q;
  end

  assign any_event = |event_flag;

endmodule
